// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int HOLD_W  = 4;

    // Saturation ceiling of the hold counter.
    localparam logic [HOLD_W-1:0] HOLD_SAT = {HOLD_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Next index in round-robin order; wraps naturally at the index width.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return i + IDX_W'(1);
    endfunction

    // Hold counter increment that sticks at the ceiling instead of wrapping.
    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] c);
        return (c == HOLD_SAT) ? c : c + HOLD_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the arbiter in the same cycle.
module rr_pick4
    import rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the four candidates starting at ptr; the first requesting one wins.
    always_comb begin
        idx   = '0;
        any   = |req;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter driving the 2-to-4 decoder select (s) and enable (e); break-before-make.
// Latency: one cycle from req sampled in IDLE to s/e valid; one cycle from release to e=0.
// Backpressure: owner holds until done, request drop or MAX_HOLD expiry; others wait their turn.
module rr_arbiter4
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [IDX_W-1:0]   s,
    output logic               e
);

    // A limit of zero disables expiry altogether.
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam bit                HOLD_ON    = (MAX_HOLD != 0);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [IDX_W-1:0]  s_q,     s_d;
    logic              e_q,     e_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              expired;
    logic              release_now;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Any one of the three causes releases once; coincident causes collapse into a single release.
    always_comb begin
        expired     = HOLD_ON && (hold_q == HOLD_LIMIT);
        release_now = done || !req[s_q] || expired;
    end

    // Next-state and output-register decode; s is only rewritten on an IDLE pick, so it is stable while e=1.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        s_d     = s_q;
        e_d     = e_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    s_d     = pick_idx;
                    e_d     = 1'b1;
                    hold_d  = HOLD_W'(1);
                    state_d = GRANT;
                end else begin
                    e_d     = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    e_d     = 1'b0;
                    ptr_d   = idx_inc(s_q);
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    hold_d  = hold_sat_inc(hold_q);
                end
            end
            default: begin
                e_d     = 1'b0;
                hold_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers; reset drops the grant without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            s_q     <= '0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            s_q     <= s_d;
            e_q     <= e_d;
        end
    end

    assign s = s_q;
    assign e = e_q;

endmodule
